// File: rtl/speedctl_pkg.sv
// Shared types and helpers for the speedctl_pi wheel speed controller.
// RAMP_STEP is only consumed when SPEEDCTL_RAMP_EN is defined.
package speedctl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    COUNT  = 2'b01,
    UPDATE = 2'b10
  } state_t;

  localparam logic signed [31:0] RAMP_STEP = 32'sd4;

  function automatic logic signed [31:0] clamp_s32(input logic signed [31:0] v,
                                                   input logic signed [31:0] lim);
    logic signed [31:0] r;
    if (v > lim) r = lim;
    else if (v < -lim) r = -lim;
    else r = v;
    return r;
  endfunction

endpackage

// File: rtl/speedctl_pi_if.sv
// Planner/encoder/H-bridge signal bundle of one speedctl_pi wheel channel.
interface speedctl_pi_if #(
  parameter int CNT_W = 16
);
  logic                    enc_a;
  logic                    enc_b;
  logic signed [15:0]      deg_s;
  logic                    pwm;
  logic                    dir;
  logic signed [CNT_W-1:0] measured;
  logic                    update;
  logic                    saturated;

  modport master (output enc_a, enc_b, deg_s,
                  input  pwm, dir, measured, update, saturated);
  modport slave  (input  enc_a, enc_b, deg_s,
                  output pwm, dir, measured, update, saturated);
endinterface

// File: rtl/speedctl_pi_quad_decoder.sv
// x1 quadrature decode: synchronise A/B, flag each rising edge of A with B as direction.
module quad_decoder (
  input  logic clk,
  input  logic enable,
  input  logic enc_a,
  input  logic enc_b,
  output logic step,
  output logic step_dir
);
  logic [1:0] a_sync_r;
  logic [1:0] b_sync_r;
  logic       a_prev_r;

  // Two-flop synchronisers plus the edge-detect history flop.
  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      a_sync_r <= 2'b00;
      b_sync_r <= 2'b00;
      a_prev_r <= 1'b0;
    end else begin
      a_sync_r <= {a_sync_r[0], enc_a};
      b_sync_r <= {b_sync_r[0], enc_b};
      a_prev_r <= a_sync_r[1];
    end
  end

  assign step     = a_sync_r[1] & ~a_prev_r;
  assign step_dir = b_sync_r[1];
endmodule

// File: rtl/speedctl_pi.sv
// speedctl_pi: windowed PI speed loop with anti-windup and sign/magnitude PWM.
// Define SPEEDCTL_RAMP_EN to slew-limit the target by RAMP_STEP counts per window.
module speedctl_pi #(
  parameter int CLK_HZ      = 16000000,
  parameter int LOG_DIVIDER = 3,
  parameter int KP_SHIFT    = 3,
  parameter int KI_SHIFT    = 1,
  parameter int DUTY_W      = 10,
  parameter int CNT_W       = 16,
  parameter int INT_MAX     = 4095
) (
  input logic          clk,
  input logic          enable,
  speedctl_pi_if.slave bus
);
  import speedctl_pkg::*;

  localparam int                      TICKS      = CLK_HZ >> LOG_DIVIDER;
  localparam logic [31:0]             TIMER_LOAD = 32'(TICKS - 1);
  localparam logic signed [31:0]      DUTY_MAX   = (32'sd1 <<< DUTY_W) - 32'sd1;
  localparam logic signed [31:0]      INT_LIM    = INT_MAX;
  localparam logic signed [31:0]      CNT_LIM32  = (32'sd1 <<< (CNT_W - 1)) - 32'sd1;
  localparam logic signed [CNT_W-1:0] CNT_LIM    = CNT_LIM32[CNT_W-1:0];
  localparam logic signed [CNT_W-1:0] CNT_NLIM   = -CNT_LIM;
  localparam logic signed [CNT_W-1:0] CNT_ONE    = CNT_W'(32'sd1);
  localparam logic [DUTY_W-1:0]       PWM_ONE    = DUTY_W'(32'd1);

  state_t                  state_r;
  logic [31:0]             timer_r;
  logic signed [CNT_W-1:0] count_r;
  logic signed [CNT_W-1:0] measured_r;
  logic signed [31:0]      integ_r;
  logic signed [DUTY_W:0]  duty_r;
  logic                    sat_r;
  logic                    update_r;
  logic [DUTY_W-1:0]       pwm_cnt_r;
  logic                    pwm_r;

  logic                    step_s;
  logic                    step_dir_s;
  logic signed [CNT_W-1:0] count_base_s;
  logic signed [CNT_W-1:0] count_next_s;
  logic signed [31:0]      target_raw_s;
  logic signed [31:0]      target_s;
  logic signed [31:0]      err_s;
  logic signed [31:0]      integ_new_s;
  logic signed [31:0]      duty_new_s;
  logic                    hold_s;
  logic [DUTY_W-1:0]       duty_mag_s;
`ifdef SPEEDCTL_RAMP_EN
  logic signed [31:0]      ramp_r;
  logic signed [31:0]      ramp_new_s;
`endif

  quad_decoder u_quad (
    .clk      (clk),
    .enable   (enable),
    .enc_a    (bus.enc_a),
    .enc_b    (bus.enc_b),
    .step     (step_s),
    .step_dir (step_dir_s)
  );

  // Saturating pulse counter; the UPDATE cycle restarts from zero but keeps its own pulse.
  always_comb begin
    count_base_s = (state_r == UPDATE) ? {CNT_W{1'b0}} : count_r;
    if (step_s && !step_dir_s && (count_base_s != CNT_LIM)) count_next_s = count_base_s + CNT_ONE;
    else if (step_s && step_dir_s && (count_base_s != CNT_NLIM)) count_next_s = count_base_s - CNT_ONE;
    else count_next_s = count_base_s;
  end

  // PI step evaluated for the UPDATE cycle, all in 32-bit signed arithmetic.
  always_comb begin
    target_raw_s = 32'(bus.deg_s) >>> LOG_DIVIDER;
`ifdef SPEEDCTL_RAMP_EN
    if (target_raw_s - ramp_r > RAMP_STEP) ramp_new_s = ramp_r + RAMP_STEP;
    else if (target_raw_s - ramp_r < -RAMP_STEP) ramp_new_s = ramp_r - RAMP_STEP;
    else ramp_new_s = target_raw_s;
    target_s = ramp_new_s;
`else
    target_s = target_raw_s;
`endif
    err_s       = target_s - 32'(count_r);
    hold_s      = sat_r && (err_s[31] == duty_r[DUTY_W]);
    integ_new_s = hold_s ? integ_r : clamp_s32(integ_r + err_s, INT_LIM);
    duty_new_s  = clamp_s32((err_s <<< KP_SHIFT) + (integ_new_s >>> KI_SHIFT), DUTY_MAX);
    duty_mag_s  = duty_r[DUTY_W] ? DUTY_W'(-duty_r) : duty_r[DUTY_W-1:0];
  end

  // Window sequencer and loop state; a zero command clears the loop on the next clock.
  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      state_r    <= IDLE;
      timer_r    <= 32'd0;
      count_r    <= {CNT_W{1'b0}};
      measured_r <= {CNT_W{1'b0}};
      integ_r    <= 32'sd0;
      duty_r     <= {(DUTY_W+1){1'b0}};
      sat_r      <= 1'b0;
      update_r   <= 1'b0;
    end else begin
      update_r <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r <= COUNT;
          timer_r <= TIMER_LOAD;
          count_r <= {CNT_W{1'b0}};
        end
        COUNT: begin
          count_r <= count_next_s;
          if (timer_r == 32'd0) state_r <= UPDATE;
          else timer_r <= timer_r - 32'd1;
        end
        UPDATE: begin
          measured_r <= count_r;
          count_r    <= count_next_s;
          integ_r    <= integ_new_s;
          duty_r     <= duty_new_s[DUTY_W:0];
          sat_r      <= (duty_new_s == DUTY_MAX) || (duty_new_s == -DUTY_MAX);
          update_r   <= 1'b1;
          timer_r    <= TIMER_LOAD;
          state_r    <= COUNT;
        end
        default: state_r <= IDLE;
      endcase
      if (bus.deg_s == 16'sd0) begin
        integ_r <= 32'sd0;
        duty_r  <= {(DUTY_W+1){1'b0}};
        sat_r   <= 1'b0;
      end
    end
  end

`ifdef SPEEDCTL_RAMP_EN
  // Ramp advances once per window and drops to zero with the command.
  always_ff @(posedge clk or negedge enable) begin
    if (!enable) ramp_r <= 32'sd0;
    else if (bus.deg_s == 16'sd0) ramp_r <= 32'sd0;
    else if (state_r == UPDATE) ramp_r <= ramp_new_s;
    else ramp_r <= ramp_r;
  end
`endif

  // Free-running PWM carrier and registered magnitude comparator.
  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      pwm_cnt_r <= {DUTY_W{1'b0}};
      pwm_r     <= 1'b0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
      pwm_r     <= (pwm_cnt_r < duty_mag_s);
    end
  end

  assign bus.pwm       = pwm_r;
  assign bus.dir       = duty_r[DUTY_W];
  assign bus.measured  = measured_r;
  assign bus.update    = update_r;
  assign bus.saturated = sat_r;
endmodule

// File: tb/tb_speedctl_pi.sv
// Bench for speedctl_pi: directed vector table, hand sequences and randomized windows vs a window-level model.
module tb_speedctl_pi;
  localparam int LOG_DIV = 3;
  localparam int CNT_W   = 16;

  logic clk    = 1'b0;
  logic enable = 1'b0;
  int   total  = 0;
  int   bad    = 0;
  int   m_integ = 0;
  int   m_duty  = 0;
  int   m_ramp  = 0;

  speedctl_pi_if #(.CNT_W(CNT_W)) bus ();

  speedctl_pi #(.CLK_HZ(8000), .LOG_DIVIDER(LOG_DIV)) dut (
    .clk    (clk),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   n;
    logic b;
    int   tgt;
    int   e_meas;
    int   e_duty;
    int   e_integ;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_set(input string name, input int e_meas, input int e_duty, input int e_integ);
    check({name, ".measured"}, int'(bus.measured), e_meas);
    check({name, ".duty"}, int'(dut.duty_r), e_duty);
    check({name, ".integ"}, int'(dut.integ_r), e_integ);
    check({name, ".dir"}, int'(bus.dir), (e_duty < 0) ? 1 : 0);
    check({name, ".saturated"}, int'(bus.saturated), (e_duty == 1023 || e_duty == -1023) ? 1 : 0);
  endtask

  function automatic int lim(input int v, input int m);
    return (v > m) ? m : ((v < -m) ? -m : v);
  endfunction

  // One window of the controller as the rules state it: pulse count in, new integ/duty out.
  function automatic void model_window(input int cnt, input int tgt);
    int target, err;
    bit frozen;
    if (tgt == 0) begin
      m_integ = 0;
      m_duty  = 0;
      m_ramp  = 0;
    end else begin
      target = tgt >>> LOG_DIV;
`ifdef SPEEDCTL_RAMP_EN
      if (target > m_ramp + 4) m_ramp = m_ramp + 4;
      else if (target < m_ramp - 4) m_ramp = m_ramp - 4;
      else m_ramp = target;
      target = m_ramp;
`endif
      err    = target - cnt;
      frozen = (m_duty == 1023 || m_duty == -1023) && ((err < 0) == (m_duty < 0));
      if (!frozen) m_integ = lim(m_integ + err, 4095);
      m_duty = lim(err * 8 + (m_integ >>> 1), 1023);
    end
  endfunction

  task automatic wait_strobe(input string name, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.update && cycles < 1200);
    if (!bus.update) begin
      total++;
      bad++;
      $display("FAIL %s: no update strobe within %0d clocks", name, cycles);
    end
  endtask

  // Starts right after a strobe, drives n A-rising edges early in the window, ends at the next strobe.
  task automatic run_window(input string name, input int n, input logic b, input int tgt, output int cnt);
    int cyc;
    bus.deg_s = 16'(tgt);
    bus.enc_b = b;
    for (int i = 0; i < n; i++) begin
      bus.enc_a = 1'b1;
      repeat (2) @(negedge clk);
      bus.enc_a = 1'b0;
      repeat (2) @(negedge clk);
    end
    wait_strobe(name, cyc);
    cnt = b ? -n : n;
    model_window(cnt, tgt);
  endtask

  initial begin
    int cyc, cnt, highs, dir_bad;
    vecs[0]  = '{0,   1'b0,  400,   0,   425,   50};
    vecs[1]  = '{0,   1'b0,  400,   0,   450,  100};
    vecs[2]  = '{0,   1'b1, -400,   0,  -375,   50};
    vecs[3]  = '{0,   1'b1, -400,   0,  -400,    0};
    vecs[4]  = '{0,   1'b1, -400,   0,  -425,  -50};
    vecs[5]  = '{50,  1'b1, -400, -50,   -25,  -50};
    vecs[6]  = '{50,  1'b1, -400, -50,   -25,  -50};
    vecs[7]  = '{0,   1'b0, 1440,   0,  1023,  130};
    vecs[8]  = '{0,   1'b0, 1440,   0,  1023,  130};
    vecs[9]  = '{180, 1'b0, 1440, 180,    65,  130};
    vecs[10] = '{0,   1'b0,    0,   0,     0,    0};
    vecs[11] = '{0,   1'b0, -1440,  0, -1023, -180};

    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    bus.deg_s = 16'sd0;
    repeat (3) @(negedge clk);
    check("rst.pwm", int'(bus.pwm), 0);
    check("rst.dir", int'(bus.dir), 0);
    check("rst.update", int'(bus.update), 0);
    check("rst.saturated", int'(bus.saturated), 0);
    check("rst.measured", int'(bus.measured), 0);

    enable = 1'b1;
    wait_strobe("first_strobe", cyc);
    check("first_strobe_latency", cyc, 1002);
    check_set("first_window", 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      run_window($sformatf("vec%0d", i), vecs[i].n, vecs[i].b, vecs[i].tgt, cnt);
`ifdef SPEEDCTL_RAMP_EN
      check_set($sformatf("vec%0d", i), cnt, m_duty, m_integ);
`else
      check_set($sformatf("vec%0d", i), vecs[i].e_meas, vecs[i].e_duty, vecs[i].e_integ);
`endif
    end

    // Target below one count per window: err settles to 0 and duty holds at integ>>>1.
    for (int i = 0; i < 3; i++) begin
      run_window($sformatf("steady%0d", i), 0, 1'b0, 4, cnt);
      check_set($sformatf("steady%0d", i), 0, m_duty, m_integ);
    end
    highs = 0;
    dir_bad = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (bus.pwm) highs++;
      if (bus.dir != (m_duty < 0)) dir_bad++;
    end
    check("steady.pwm_high_clocks", highs, (m_duty < 0) ? -m_duty : m_duty);
    check("steady.dir_glitches", dir_bad, 0);
    wait_strobe("steady_tail", cyc);
    model_window(0, 4);
    check_set("steady_tail", 0, m_duty, m_integ);

    // Zero command mid-window: loop clears next clock, pwm stays low for a full period.
    repeat (300) @(negedge clk);
    bus.deg_s = 16'sd0;
    repeat (2) @(negedge clk);
    check("zero.duty", int'(dut.duty_r), 0);
    check("zero.saturated", int'(bus.saturated), 0);
    highs = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (bus.pwm) highs++;
    end
    check("zero.pwm_high_clocks", highs, 0);
    wait_strobe("zero_tail", cyc);
    model_window(0, 0);
    check_set("zero_tail", 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      int tgt, n;
      logic b;
      tgt = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 2880)) - 1440;
      n   = int'($urandom_range(0, 180));
      b   = 1'($urandom_range(0, 1));
      run_window($sformatf("rnd%0d", i), n, b, tgt, cnt);
      check_set($sformatf("rnd%0d", i), cnt, m_duty, m_integ);
    end

`ifdef SPEEDCTL_RAMP_EN
    run_window("ramp_clear", 0, 1'b0, 0, cnt);
    check_set("ramp_clear", 0, 0, 0);
    for (int k = 1; k <= 13; k++) begin
      run_window($sformatf("ramp%0d", k), 0, 1'b0, 400, cnt);
      check($sformatf("ramp%0d.target", k), int'(dut.ramp_r), (4 * k > 50) ? 50 : 4 * k);
      check_set($sformatf("ramp%0d", k), 0, m_duty, m_integ);
    end
`endif

    // Reset in the middle of a window after a window with pulses.
    run_window("pre_reset", 30, 1'b0, 800, cnt);
    check_set("pre_reset", cnt, m_duty, m_integ);
    repeat (500) @(negedge clk);
    #2 enable = 1'b0;
    #1;
    check("midrst.pwm", int'(bus.pwm), 0);
    check("midrst.dir", int'(bus.dir), 0);
    check("midrst.update", int'(bus.update), 0);
    check("midrst.saturated", int'(bus.saturated), 0);
    check("midrst.measured", int'(bus.measured), 0);
    check("midrst.duty", int'(dut.duty_r), 0);
    m_integ = 0;
    m_duty  = 0;
    m_ramp  = 0;
    @(negedge clk);
    enable = 1'b1;
    wait_strobe("restart", cyc);
    check("restart_latency", cyc, 1002);
    model_window(0, 800);
    check_set("restart", 0, m_duty, m_integ);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/speedctl_pi.md
Name: speedctl_pi

Overview:
- Next-generation closed-loop motor speed controller.
- Bidirectional: takes a signed target in deg/s, decodes a quadrature encoder (A/B) to get signed measured speed, and runs a PI loop with anti-windup once per measurement window.
- Drives a sign/magnitude PWM output pair (pwm, dir) to the H-bridge.
- Sits between the robot's motion planner and each wheel's motor driver; one instance per wheel.

Parameters:
- CLK_HZ, 16000000, input clock frequency; window length TICKS = CLK_HZ >> LOG_DIVIDER.
- LOG_DIVIDER, 3, windows per second = 2^LOG_DIVIDER (default 125 ms).
- KP_SHIFT, 3, proportional gain = 2^KP_SHIFT.
- KI_SHIFT, 1, integral term = integ >>> KI_SHIFT.
- DUTY_W, 10, PWM resolution; period = 2^DUTY_W clocks; DUTY_MAX = 2^DUTY_W-1.
- CNT_W, 16, width of the signed window pulse counter.
- INT_MAX, 4095, integrator clamp magnitude.

Ports:
- clk  in  1  system clock (CLK_HZ).
- enable  in  1  asynchronous active-low reset.
- enc_a  in  1  encoder channel A, asynchronous.
- enc_b  in  1  encoder channel B, asynchronous.
- deg_s  in  16  signed target deg/s, two's complement, range ±1440.
- pwm  out  1  PWM magnitude output.
- dir  out  1  0 = forward (duty >= 0), 1 = reverse.
- measured  out  CNT_W  signed pulse count of the last completed window.
- update  out  1  one-cycle strobe; duty and measured were refreshed this cycle.
- saturated  out  1  high while |duty| is clamped at DUTY_MAX.

Behaviour:
- Reset (enable=0, async): all outputs 0, duty=0, integ=0, counter=0, state=IDLE, sync flops 0.
- Encoder path:
  - 2-flop synchroniser per channel plus one edge-detect flop.
  - x1 decode on each rising edge of synchronised A: +1 if B=0 (forward), -1 if B=1.
  - Latency from pin to count: 3 clocks.
- FSM IDLE -> COUNT:
  - IDLE lasts 1 cycle, then loads timer = TICKS-1.
- COUNT:
  - Accumulate pulses; decrement timer.
  - When timer = 0, go to UPDATE.
  - Counter saturates at ±(2^(CNT_W-1)-1), no wrap.
- UPDATE (1 cycle):
  - measured <= counter.
  - target_cnt = deg_s >>> LOG_DIVIDER (arithmetic).
  - err = target_cnt - counter.
  - integ <= clamp(integ + err, ±INT_MAX), except held when saturated and sign(err) = sign(duty) (anti-windup).
  - duty <= clamp((err <<< KP_SHIFT) + (integ_new >>> KI_SHIFT), ±DUTY_MAX).
  - All arithmetic is 32-bit signed.
  - Counter reloads with the pulse seen in this cycle, so no pulse is lost.
  - Timer reloads TICKS-1; return to COUNT.
- update is high the cycle after UPDATE, coincident with the new measured and duty values.
- deg_s = 0:
  - duty and integ cleared the next clock.
  - pwm low within one PWM period.
  - Windows and measured keep running.
- deg_s change mid-window: sampled only in the UPDATE cycle.
- PWM:
  - Free-running DUTY_W-bit counter.
  - pwm = (pwm_cnt < |duty|).
  - dir = duty[msb].
  - |duty| = DUTY_MAX gives pwm high except at pwm_cnt = DUTY_MAX.
  - |duty| = 0 gives pwm constant low.
- saturated = (|duty| == DUTY_MAX), registered with duty.
- Reset mid-window: immediate clear; the restart goes through IDLE, so the first update strobe comes TICKS+2 clocks after enable rises.

Optional Feature:
- Macro SPEEDCTL_RAMP_EN.
- Defined:
  - target_cnt is slew-limited: an internal ramp register moves toward deg_s >>> LOG_DIVIDER by at most RAMP_STEP (localparam 4) counts per window.
  - The ramp resets to 0 and is cleared when deg_s = 0.
- Undefined: target_cnt is used directly; no ramp register exists.

Decomposition:
- Package speedctl_pkg:
  - FSM state encoding: IDLE = 2'b00, COUNT = 2'b01, UPDATE = 2'b10.
  - Signed clamp function.
  - RAMP_STEP.
- Sub-module quad_decoder: synchroniser, edge detect and direction. Outputs step (1-cycle) and step_dir.
- The PWM comparator stays inline.

Test Plan (bench overrides CLK_HZ=8000, LOG_DIVIDER=3, so TICKS=1000):
1. Reset and first strobe.
   - Stimulus: enable=0, then released.
   - Response: with enable=0, pwm=dir=update=saturated=0 and measured=0. After release, the first update strobe occurs exactly 1002 clocks later.
2. Open loop, forward.
   - Stimulus: deg_s=+400, no encoder edges.
   - Response: update 1 gives err=50, integ=50, duty=425. Update 2 gives integ=100, duty=450. dir=0.
3. Reverse measurement.
   - Stimulus: deg_s=-400, 50 A-rising edges per window with B=1.
   - Response: measured=-50, err=0, dir stays 1 once duty<0.
4. Saturation and anti-windup.
   - Stimulus: deg_s=+1440, no edges.
   - Response: duty clamps at 1023, saturated=1, integ frozen at its value when clamping began. Then 180 edges/window: duty = integ>>>1 on the next update and saturated=0.
5. Zero target and reset mid-window.
   - Stimulus: deg_s=0 mid-window.
   - Response: duty=0 and pwm low within 1024 clocks.
   - Stimulus: enable low at timer=500.
   - Response: all outputs 0 asynchronously.
6. SPEEDCTL_RAMP_EN build.
   - Stimulus: deg_s step 0 -> +400.
   - Response: target_cnt goes 4, 8, 12 … reaching 50 at window 13.
